// File: rtl/nc_mul8_seq_ctrl.sv
// Sequential 8x8 multiplier controller: walks one shared 4x4 partial-product
// unit over the LL/LH/HL/HH sub-products and accumulates the shifted results.
module nc_mul8_seq_ctrl #(
  parameter int PP_LAT  = 0,
  parameter bit KEEP_LL = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [7:0]  in_a,
  input  logic [7:0]  in_b,
  output logic [3:0]  pp_a,
  output logic [3:0]  pp_b,
  output logic [1:0]  pp_sel,
  input  logic [7:0]  pp_prod,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] out_prod,
  output logic        busy
);

  typedef enum logic [1:0] {IDLE = 2'd0, CALC = 2'd1, DONE = 2'd2} state_t;

  localparam logic [1:0] LAT   = PP_LAT[1:0];
  localparam logic [1:0] FIRST = KEEP_LL ? 2'd0 : 2'd1;

  state_t      state_r, state_nx_s;
  logic [7:0]  a_r, b_r;
  logic [15:0] acc_r, acc_sum_s, out_prod_r;
  logic [1:0]  step_r, cnt_r, pp_sel_r;
  logic [3:0]  pp_a_r, pp_b_r;
  logic        out_valid_r;
  logic        in_ready_s, accept_s, step_end_s, last_s;

  // Steps 2 and 3 use the high nibble of a; steps 1 and 3 the high nibble of b.
  function automatic logic [3:0] nib_a(input logic [7:0] v, input logic [1:0] step);
    nib_a = step[1] ? v[7:4] : v[3:0];
  endfunction

  function automatic logic [3:0] nib_b(input logic [7:0] v, input logic [1:0] step);
    nib_b = step[0] ? v[7:4] : v[3:0];
  endfunction

  function automatic logic [15:0] shift_term(input logic [7:0] p, input logic [1:0] step);
    logic [15:0] w;
    w = {8'd0, p};
    case (step)
      2'd0:       shift_term = w;
      2'd1, 2'd2: shift_term = w << 4;
      2'd3:       shift_term = w << 8;
      default:    shift_term = w;
    endcase
  endfunction

  // Handshake decode, accumulation sum and next-state logic.
  always_comb begin
    state_nx_s = state_r;
    in_ready_s = !rst && ((state_r == IDLE) || ((state_r == DONE) && out_ready));
    accept_s   = in_valid && in_ready_s;
    step_end_s = (state_r == CALC) && (cnt_r == LAT);
    last_s     = step_end_s && (step_r == 2'd3);
    acc_sum_s  = acc_r + shift_term(pp_prod, step_r);
    case (state_r)
      IDLE: begin
        if (accept_s) state_nx_s = CALC;
        else          state_nx_s = IDLE;
      end
      CALC: begin
        if (last_s) state_nx_s = DONE;
        else        state_nx_s = CALC;
      end
      DONE: begin
        if (out_ready && in_valid) state_nx_s = CALC;
        else if (out_ready)        state_nx_s = IDLE;
        else                       state_nx_s = DONE;
      end
      default: state_nx_s = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state_r <= IDLE;
    else     state_r <= state_nx_s;
  end

  // Operand latch, step sequencing, partial-product drive and accumulation.
  always_ff @(posedge clk) begin
    if (rst) begin
      a_r         <= 8'd0;
      b_r         <= 8'd0;
      acc_r       <= 16'd0;
      step_r      <= 2'd0;
      cnt_r       <= 2'd0;
      pp_a_r      <= 4'd0;
      pp_b_r      <= 4'd0;
      pp_sel_r    <= 2'd0;
      out_prod_r  <= 16'd0;
      out_valid_r <= 1'b0;
    end else begin
      if (accept_s) begin
        a_r      <= in_a;
        b_r      <= in_b;
        acc_r    <= 16'd0;
        step_r   <= FIRST;
        cnt_r    <= 2'd0;
        pp_a_r   <= nib_a(in_a, FIRST);
        pp_b_r   <= nib_b(in_b, FIRST);
        pp_sel_r <= FIRST;
      end else if (step_end_s) begin
        acc_r <= acc_sum_s;
        cnt_r <= 2'd0;
        if (last_s) begin
          out_prod_r <= acc_sum_s;
          pp_a_r     <= 4'd0;
          pp_b_r     <= 4'd0;
          pp_sel_r   <= 2'd0;
        end else begin
          step_r   <= step_r + 2'd1;
          pp_a_r   <= nib_a(a_r, step_r + 2'd1);
          pp_b_r   <= nib_b(b_r, step_r + 2'd1);
          pp_sel_r <= step_r + 2'd1;
        end
      end else if (state_r == CALC) begin
        cnt_r <= cnt_r + 2'd1;
      end
      // out_valid falls on the handshake even when a new op is accepted there.
      if (last_s)                        out_valid_r <= 1'b1;
      else if (out_valid_r && out_ready) out_valid_r <= 1'b0;
    end
  end

  assign in_ready  = in_ready_s;
  assign pp_a      = pp_a_r;
  assign pp_b      = pp_b_r;
  assign pp_sel    = pp_sel_r;
  assign out_valid = out_valid_r;
  assign out_prod  = out_prod_r;
  assign busy      = (state_r == CALC);

endmodule

// File: tb/tb_nc_mul8_seq_ctrl.sv
// Bench for nc_mul8_seq_ctrl: three instances (PP_LAT/KEEP_LL = 0/1, 0/0, 2/1)
// each paired with an exact 4x4 multiplier model of matching latency.
module tb_nc_mul8_seq_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  in_a = 8'd0, in_b = 8'd0;
  logic        in_valid_v [3];
  logic        out_ready_v[3];
  logic        in_ready_v [3];
  logic        out_valid_v[3];
  logic        busy_v     [3];
  logic [15:0] out_prod_v [3];
  logic [3:0]  ppa_v      [3];
  logic [3:0]  ppb_v      [3];
  logic [1:0]  pps_v      [3];
  logic [7:0]  ppp_v      [3];

  int compared = 0, mismatched = 0;
  logic [9:0]  q0[$], q1[$], q2[$];
  logic [15:0] expq[$];
  int          got_n = 0;
  bit          stream_on = 1'b0;

  always #5 clk = ~clk;

  for (genvar gi = 0; gi < 3; gi++) begin : g_dut
    nc_mul8_seq_ctrl #(.PP_LAT((gi == 2) ? 2 : 0), .KEEP_LL((gi == 1) ? 1'b0 : 1'b1)) u_dut (
      .clk(clk), .rst(rst), .in_valid(in_valid_v[gi]), .in_ready(in_ready_v[gi]),
      .in_a(in_a), .in_b(in_b), .pp_a(ppa_v[gi]), .pp_b(ppb_v[gi]), .pp_sel(pps_v[gi]),
      .pp_prod(ppp_v[gi]), .out_valid(out_valid_v[gi]), .out_ready(out_ready_v[gi]),
      .out_prod(out_prod_v[gi]), .busy(busy_v[gi]));
    if (gi == 2) begin : g_lat
      logic [7:0] d1, d2;
      always @(posedge clk) begin
        d1 <= {4'd0, ppa_v[gi]} * {4'd0, ppb_v[gi]};
        d2 <= d1;
      end
      assign ppp_v[gi] = d2;
    end else begin : g_comb
      assign ppp_v[gi] = {4'd0, ppa_v[gi]} * {4'd0, ppb_v[gi]};
    end
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    compared++;
    if (got !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  function automatic int lat_of(input int k);
    return (k == 0) ? 4 : (k == 1) ? 3 : 12;
  endfunction

  // Truncated variant simply omits the al*bl term from the full product.
  function automatic logic [15:0] model(input int k, input logic [7:0] a, input logic [7:0] b);
    int p;
    p = int'(a) * int'(b);
    if (k == 1) p = p - int'(a[3:0]) * int'(b[3:0]);
    return p[15:0];
  endfunction

  // Record partial-product drive every CALC cycle.
  always @(negedge clk) begin
    if (busy_v[0]) q0.push_back({pps_v[0], ppa_v[0], ppb_v[0]});
    if (busy_v[1]) q1.push_back({pps_v[1], ppa_v[1], ppb_v[1]});
    if (busy_v[2]) q2.push_back({pps_v[2], ppa_v[2], ppb_v[2]});
  end

  // Streaming result collector.
  always @(negedge clk) begin
    if (stream_on && out_valid_v[0] && out_ready_v[0]) begin
      got_n++;
      if (expq.size() == 0) chk("stream_extra", 32'd1, 32'd0);
      else                  chk("stream_prod", {16'd0, out_prod_v[0]}, {16'd0, expq.pop_front()});
    end
  end

  task automatic op(input int k, input logic [7:0] a, input logic [7:0] b,
                    output logic [15:0] prod, output int lat);
    int n;
    @(negedge clk);
    in_a = a; in_b = b; in_valid_v[k] = 1'b1; out_ready_v[k] = 1'b1;
    n = 0;
    while (!in_ready_v[k] && n < 50) begin @(negedge clk); n++; end
    q0.delete(); q1.delete(); q2.delete();
    @(posedge clk);
    #1 in_valid_v[k] = 1'b0;
    lat = 0;
    do begin @(posedge clk); lat++; #1; end while (!out_valid_v[k] && lat < 60);
    prod = out_prod_v[k];
    @(posedge clk);
  endtask

  task automatic chk_seq(input int k, input logic [7:0] a, input logic [7:0] b);
    logic [9:0] q[$];
    int per, first, sel;
    logic [3:0] ea, eb;
    if (k == 0) q = q0; else if (k == 1) q = q1; else q = q2;
    per   = (k == 2) ? 3 : 1;
    first = (k == 1) ? 1 : 0;
    chk($sformatf("seq_len_k%0d", k), q.size(), lat_of(k));
    for (int i = 0; i < q.size() && i < lat_of(k); i++) begin
      sel = first + i / per;
      ea  = (sel >= 2) ? a[7:4] : a[3:0];
      eb  = (sel == 1 || sel == 3) ? b[7:4] : b[3:0];
      chk($sformatf("seq_k%0d_%0d", k, i), {22'd0, q[i]}, {22'd0, sel[1:0], ea, eb});
    end
  endtask

  typedef struct {
    int          k;
    logic [7:0]  a;
    logic [7:0]  b;
    logic [15:0] exp;
    int          lat;
  } vec_t;

  initial begin
    vec_t        tbl[7];
    logic [15:0] prod, e1;
    int          lat, n;
    logic [7:0]  ra, rb;

    tbl[0] = '{0, 8'd200, 8'd150, 16'h7530, 4};
    tbl[1] = '{1, 8'hFF,  8'hFF,  16'hFD20, 3};
    tbl[2] = '{1, 8'h0F,  8'h0F,  16'h0000, 3};
    tbl[3] = '{2, 8'hAB,  8'hCD,  16'h88EF, 12};
    tbl[4] = '{0, 8'h00,  8'hFF,  16'h0000, 4};
    tbl[5] = '{0, 8'h10,  8'h10,  16'h0100, 4};
    tbl[6] = '{2, 8'hFF,  8'hFF,  16'hFE01, 12};

    for (int k = 0; k < 3; k++) begin in_valid_v[k] = 1'b0; out_ready_v[k] = 1'b1; end

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      chk("rst_in_ready", {31'd0, in_ready_v[k]}, 32'd0);
      chk("rst_out_valid", {31'd0, out_valid_v[k]}, 32'd0);
      chk("rst_busy", {31'd0, busy_v[k]}, 32'd0);
      chk("rst_out_prod", {16'd0, out_prod_v[k]}, 32'd0);
      chk("rst_pp", {22'd0, pps_v[k], ppa_v[k], ppb_v[k]}, 32'd0);
    end
    rst = 1'b0;
    #1;
    for (int k = 0; k < 3; k++) chk("idle_in_ready", {31'd0, in_ready_v[k]}, 32'd1);

    // Directed vectors
    for (int i = 0; i < 7; i++) begin
      op(tbl[i].k, tbl[i].a, tbl[i].b, prod, lat);
      chk($sformatf("vec%0d_prod", i), {16'd0, prod}, {16'd0, tbl[i].exp});
      chk($sformatf("vec%0d_lat", i), lat, tbl[i].lat);
      chk_seq(tbl[i].k, tbl[i].a, tbl[i].b);
    end

    // Randomized ops against the model on every configuration
    for (int k = 0; k < 3; k++) begin
      for (int i = 0; i < 6; i++) begin
        ra = 8'($urandom_range(255)); rb = 8'($urandom_range(255));
        op(k, ra, rb, prod, lat);
        chk($sformatf("rand_k%0d_prod", k), {16'd0, prod}, {16'd0, model(k, ra, rb)});
        chk($sformatf("rand_k%0d_lat", k), lat, lat_of(k));
      end
    end

    // Backpressure then same-edge accept
    @(negedge clk);
    in_a = 8'h12; in_b = 8'h34; in_valid_v[0] = 1'b1; out_ready_v[0] = 1'b0;
    n = 0;
    while (!in_ready_v[0] && n < 50) begin @(negedge clk); n++; end
    @(posedge clk);
    #1 in_a = 8'h56; in_b = 8'h78;
    n = 0;
    @(negedge clk);
    while (!out_valid_v[0] && n < 50) begin @(negedge clk); n++; end
    e1 = model(0, 8'h12, 8'h34);
    for (int i = 0; i < 10; i++) begin
      chk("bp_prod", {16'd0, out_prod_v[0]}, {16'd0, e1});
      chk("bp_in_ready", {31'd0, in_ready_v[0]}, 32'd0);
      chk("bp_out_valid", {31'd0, out_valid_v[0]}, 32'd1);
      @(negedge clk);
    end
    out_ready_v[0] = 1'b1;
    #1 chk("bp_same_edge_ready", {31'd0, in_ready_v[0]}, 32'd1);
    @(posedge clk);
    #1;
    in_valid_v[0] = 1'b0;
    chk("bp_drop_valid", {31'd0, out_valid_v[0]}, 32'd0);
    chk("bp_busy", {31'd0, busy_v[0]}, 32'd1);
    lat = 0;
    do begin @(posedge clk); lat++; #1; end while (!out_valid_v[0] && lat < 60);
    chk("bp_next_prod", {16'd0, out_prod_v[0]}, {16'd0, model(0, 8'h56, 8'h78)});
    chk("bp_next_lat", lat, 4);
    @(posedge clk);

    // Reset during step 2
    @(negedge clk);
    in_a = 8'hEE; in_b = 8'h77; in_valid_v[0] = 1'b1;
    n = 0;
    while (!in_ready_v[0] && n < 50) begin @(negedge clk); n++; end
    @(posedge clk);
    #1 in_valid_v[0] = 1'b0;
    n = 0;
    @(negedge clk);
    while (!(busy_v[0] && pps_v[0] == 2'd2) && n < 20) begin @(negedge clk); n++; end
    chk("rstmid_reached_step2", {31'd0, pps_v[0] == 2'd2}, 32'd1);
    rst = 1'b1;
    @(negedge clk);
    chk("rstmid_in_ready_in_rst", {31'd0, in_ready_v[0]}, 32'd0);
    rst = 1'b0;
    #1;
    chk("rstmid_out_valid", {31'd0, out_valid_v[0]}, 32'd0);
    chk("rstmid_busy", {31'd0, busy_v[0]}, 32'd0);
    chk("rstmid_pp", {22'd0, pps_v[0], ppa_v[0], ppb_v[0]}, 32'd0);
    chk("rstmid_in_ready", {31'd0, in_ready_v[0]}, 32'd1);
    op(0, 8'h10, 8'h10, prod, lat);
    chk("rstmid_after_prod", {16'd0, prod}, 32'h0100);

    // Back-to-back stream of 8 random pairs
    stream_on = 1'b1;
    out_ready_v[0] = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      ra = 8'($urandom_range(255)); rb = 8'($urandom_range(255));
      in_a = ra; in_b = rb; in_valid_v[0] = 1'b1;
      n = 0;
      while (!in_ready_v[0] && n < 50) begin @(negedge clk); n++; end
      expq.push_back(model(0, ra, rb));
      @(posedge clk);
    end
    #1 in_valid_v[0] = 1'b0;
    n = 0;
    while (got_n < 8 && n < 40) begin @(negedge clk); n++; end
    chk("stream_count", got_n, 8);
    chk("stream_left", expq.size(), 0);
    stream_on = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
